// File: rtl/axi_lite_arbiter.sv
// axi_lite_arbiter: N-master to 1-slave AXI4-Lite arbiter.
// Read and write channels are arbitrated independently, each with its own
// round-robin pointer. One outstanding transaction per channel.
// Master-side buses are flattened into packed arrays indexed by master number;
// rdata/rresp/bresp are broadcast, so only one copy of each is provided.
//
// state    | meaning
// RD_IDLE  | no read in flight, arbitrate among arvalid requesters
// RD_ADDR  | forward AR of the granted master until the slave accepts it
// RD_DATA  | forward R from the slave to the granted master
// WR_IDLE  | no write in flight, arbitrate among awvalid requesters
// WR_AW_W  | forward AW and W of the granted master, each exactly once
// WR_B     | forward B from the slave to the granted master
module axi_lite_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32
) (
  input  logic                                clk,
  input  logic                                reset,
  // upstream masters
  input  logic [NUM_MASTERS-1:0][ADDR_W-1:0]  m_araddr,
  input  logic [NUM_MASTERS-1:0]              m_arvalid,
  output logic [NUM_MASTERS-1:0]              m_arready,
  output logic [31:0]                         m_rdata,
  output logic [1:0]                          m_rresp,
  output logic [NUM_MASTERS-1:0]              m_rvalid,
  input  logic [NUM_MASTERS-1:0]              m_rready,
  input  logic [NUM_MASTERS-1:0][ADDR_W-1:0]  m_awaddr,
  input  logic [NUM_MASTERS-1:0]              m_awvalid,
  output logic [NUM_MASTERS-1:0]              m_awready,
  input  logic [NUM_MASTERS-1:0][31:0]        m_wdata,
  input  logic [NUM_MASTERS-1:0][3:0]         m_wmask,
  input  logic [NUM_MASTERS-1:0]              m_wvalid,
  output logic [NUM_MASTERS-1:0]              m_wready,
  output logic [1:0]                          m_bresp,
  output logic [NUM_MASTERS-1:0]              m_bvalid,
  input  logic [NUM_MASTERS-1:0]              m_bready,
  // downstream slave
  output logic [ADDR_W-1:0]                   s_araddr,
  output logic                                s_arvalid,
  input  logic                                s_arready,
  input  logic [31:0]                         s_rdata,
  input  logic [1:0]                          s_rresp,
  input  logic                                s_rvalid,
  output logic                                s_rready,
  output logic [ADDR_W-1:0]                   s_awaddr,
  output logic                                s_awvalid,
  input  logic                                s_awready,
  output logic [31:0]                         s_wdata,
  output logic [3:0]                          s_wmask,
  output logic                                s_wvalid,
  input  logic                                s_wready,
  input  logic [1:0]                          s_bresp,
  input  logic                                s_bvalid,
  output logic                                s_bready
);

  localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_AW_W, WR_B}     wr_state_t;

  rd_state_t        rd_state;
  wr_state_t        wr_state;
  logic [PTR_W-1:0] rd_grant, wr_grant;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W-1:0] rd_win, wr_win;
  logic             aw_done, w_done;
  logic             aw_hs, w_hs;

  // First requester at or after ptr, wrapping past the last master.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                               input logic [PTR_W-1:0]       ptr);
    logic [PTR_W-1:0] win;
    logic             hit;
    int               idx;
    win = '0;
    hit = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (!hit && req[idx[PTR_W-1:0]]) begin
        hit = 1'b1;
        win = idx[PTR_W-1:0];
      end
    end
    return win;
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] g);
    if (g == PTR_W'(NUM_MASTERS - 1)) return '0;
    return g + 1'b1;
  endfunction

  assign rd_win = rr_pick(m_arvalid, rd_ptr);
  assign wr_win = rr_pick(m_awvalid, wr_ptr);
  assign aw_hs  = s_awvalid && s_awready;
  assign w_hs   = s_wvalid && s_wready;

  // Read-channel steering: only the granted master sees ready/valid.
  always_comb begin
    s_araddr  = '0;
    s_arvalid = 1'b0;
    s_rready  = 1'b0;
    m_arready = '0;
    m_rvalid  = '0;
    m_rdata   = s_rdata;
    m_rresp   = s_rresp;
    case (rd_state)
      RD_ADDR: begin
        s_arvalid           = m_arvalid[rd_grant];
        s_araddr            = m_araddr[rd_grant];
        m_arready[rd_grant] = s_arready;
      end
      RD_DATA: begin
        m_rvalid[rd_grant] = s_rvalid;
        s_rready           = m_rready[rd_grant];
      end
      default: ;
    endcase
  end

  // Write-channel steering: AW and W are each forwarded until accepted once.
  always_comb begin
    s_awaddr  = '0;
    s_awvalid = 1'b0;
    s_wdata   = '0;
    s_wmask   = '0;
    s_wvalid  = 1'b0;
    s_bready  = 1'b0;
    m_awready = '0;
    m_wready  = '0;
    m_bvalid  = '0;
    m_bresp   = s_bresp;
    case (wr_state)
      WR_AW_W: begin
        s_awaddr            = m_awaddr[wr_grant];
        s_wdata             = m_wdata[wr_grant];
        s_wmask             = m_wmask[wr_grant];
        s_awvalid           = m_awvalid[wr_grant] && !aw_done;
        s_wvalid            = m_wvalid[wr_grant] && !w_done;
        m_awready[wr_grant] = s_awready && !aw_done;
        m_wready[wr_grant]  = s_wready && !w_done;
      end
      WR_B: begin
        m_bvalid[wr_grant] = s_bvalid;
        s_bready           = m_bready[wr_grant];
      end
      default: ;
    endcase
  end

  // Read FSM: registered grant gives a one-cycle arbitration bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state <= RD_IDLE;
      rd_grant <= '0;
      rd_ptr   <= '0;
    end else begin
      case (rd_state)
        RD_IDLE: if (|m_arvalid) begin
          rd_grant <= rd_win;
          rd_ptr   <= next_ptr(rd_win);
          rd_state <= RD_ADDR;
        end
        RD_ADDR: if (s_arvalid && s_arready) rd_state <= RD_DATA;
        RD_DATA: if (s_rvalid && s_rready) rd_state <= RD_IDLE;
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  // Write FSM: only awvalid requests a grant; AW/W may finish in any order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state <= WR_IDLE;
      wr_grant <= '0;
      wr_ptr   <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      case (wr_state)
        WR_IDLE: if (|m_awvalid) begin
          wr_grant <= wr_win;
          wr_ptr   <= next_ptr(wr_win);
          aw_done  <= 1'b0;
          w_done   <= 1'b0;
          wr_state <= WR_AW_W;
        end
        WR_AW_W: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs) w_done <= 1'b1;
          if ((aw_done || aw_hs) && (w_done || w_hs)) wr_state <= WR_B;
        end
        WR_B: if (s_bvalid && s_bready) wr_state <= WR_IDLE;
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

endmodule
